alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the CPU's single ALU between two requesters: req 0 is the main control FSM's execute state, req 1 is an auxiliary unit such as address/PC arithmetic.
- Grants one requester at a time and latches its function code and operand select.
- Drives a one-cycle start strobe to the ALU, waits for alu_end, then returns a one-cycle done pulse to the winner.
- A watchdog aborts operations whose alu_end never arrives.

Parameters:
- TIMEOUT, 16: max cycles in WAIT before abort; 0 disables the watchdog.
- FUNC_W, 3: width of the ALU function code.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  2  level request per requester; held until that requester's done
- func0  input  FUNC_W  ALU function code for requester 0
- func1  input  FUNC_W  ALU function code for requester 1
- sel0  input  1  ALU operand-select for requester 0
- sel1  input  1  ALU operand-select for requester 1
- gnt  output  2  one-hot grant, high from START through DONE
- done  output  2  one-cycle completion pulse to the granted requester
- err  output  1  one-cycle pulse coincident with done when the watchdog aborted
- alu_start  output  1  one-cycle start strobe to the ALU
- alu_func  output  FUNC_W  latched function code of the current owner
- alu_in_sel  output  1  latched operand select of the current owner
- alu_end  input  1  ALU completion, sampled only in WAIT
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (async on rst high): state=IDLE, gnt=0, done=0, err=0, alu_start=0, alu_func=0, alu_in_sel=0, busy=0, watchdog count=0, last=1 (so requester 0 wins the first tie).
- FSM states are IDLE, START, WAIT, DONE. All outputs are registered or decoded from registered state; no combinational path from req or alu_end to any output.
- IDLE:
  - If req!=0, pick a winner, latch its func/sel into alu_func/alu_in_sel, set gnt one-hot, go to START.
  - Single requester: it wins.
  - Both requesting: the one not equal to last wins (round-robin).
  - Else stay in IDLE.
- START: alu_start=1 for exactly this cycle; clear watchdog; go to WAIT.
- WAIT:
  - alu_end=1 at the edge: go to DONE with err=0.
  - Else if TIMEOUT!=0 and count==TIMEOUT-1: go to DONE with err=1.
  - Else count+1. Counter width is clog2(TIMEOUT+1), with no wrap before the abort.
- DONE: done[winner]=1 and err as set, for one cycle; last<=winner; gnt cleared at the next edge; go to IDLE.
- Latency:
  - req sampled at edge E gives START in E..E+1 and WAIT from E+1.
  - alu_end sampled at edge E+2 gives done during E+2..E+3. Minimum req-to-done is 3 cycles.
  - At least one IDLE cycle separates back-to-back grants.
- Boundary cases:
  - alu_end in IDLE/START/DONE: ignored.
  - alu_end coincident with the watchdog expiry: treated as success, err=0.
  - Granted requester drops req mid-operation: the operation completes and done still pulses.
  - func/sel changing after grant: no effect on alu_func/alu_in_sel.
  - Non-granted requester: waits, never sees done.
  - rst mid-operation: immediate return to reset values; no done/err issued; in-flight op abandoned.
  - alu_func/alu_in_sel hold their last value in IDLE.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties, last is not consulted, and requester 1 may starve.
- Undefined: round-robin as above.
- Grant timing, FSM and watchdog are identical in both builds.

Test Plan:
- rst pulse mid-WAIT → all outputs 0 within the same cycle, IDLE next; a later req=01 is served normally.
- req=01, func0=3'b010, sel0=1, alu_end 3 cycles after alu_start → gnt=01, alu_start one cycle, alu_func=010, alu_in_sel=1, done=01 one cycle, err=0, busy low after DONE.
- req=11 held through 4 operations, alu_end 2 cycles after each start → grant order 0,1,0,1, one IDLE cycle between grants; with ALU_ARB_FIXED_PRIO_EN the order is 0,0,0,0.
- req=10, alu_end never asserted, TIMEOUT=16 → done=10 and err=1 exactly 16 cycles after the WAIT entry; IDLE next.
- alu_end asserted on the same edge as watchdog expiry → done pulse with err=0; alu_end pulse in IDLE → no state change.
- Requester 0 granted, req0 dropped and func0 changed one cycle after grant → alu_func unchanged, done=01 still issued.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between two requesters. Requester 0 is the
//               main control FSM's execute state and requester 1 is an
//               auxiliary unit such as address/PC arithmetic. The arbiter
//               grants one requester at a time and latches that requester's
//               function code and operand select. It then issues a one-cycle
//               start strobe, waits for alu_end, and returns a one-cycle
//               done pulse to the winner. A watchdog aborts an operation
//               whose alu_end never arrives and flags it on err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT    max cycles spent in WAIT before abort (0 disables watchdog)
//   FUNC_W     width of the ALU function code
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   req        in   2       level request per requester, held until done
//   func0/1    in   FUNC_W  ALU function code of requester 0/1
//   sel0/1     in   1       ALU operand select of requester 0/1
//   gnt        out  2       one-hot grant, high from START through DONE
//   done       out  2       one-cycle completion pulse to the winner
//   err        out  1       pulse with done when the watchdog aborted
//   alu_start  out  1       one-cycle ALU start strobe
//   alu_func   out  FUNC_W  latched function code of the current owner
//   alu_in_sel out  1       latched operand select of the current owner
//   alu_end    in   1       ALU completion, only looked at in WAIT
//   busy       out  1       high whenever the FSM is not IDLE
// Build option
//   ALU_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a tie and
//                          requester 1 may starve; otherwise ties are
//                          resolved round-robin.
// ============================================================================
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned FUNC_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [FUNC_W-1:0] func0,
  input  logic [FUNC_W-1:0] func1,
  input  logic              sel0,
  input  logic              sel1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              err,
  output logic              alu_start,
  output logic [FUNC_W-1:0] alu_func,
  output logic              alu_in_sel,
  input  logic              alu_end,
  output logic              busy
);

  // Counter is wide enough to hold TIMEOUT-1 without wrapping. A disabled
  // watchdog still gets a 1-bit counter so the declarations stay legal.
  localparam int unsigned       c_cnt_w    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = (TIMEOUT > 0) ? c_cnt_w'(TIMEOUT - 1) : '0;
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           gnt_q,   gnt_d;
  logic                 err_q,   err_d;
  logic [FUNC_W-1:0]    func_q,  func_d;
  logic                 sel_q,   sel_d;
  logic [c_cnt_w-1:0]   cnt_q,   cnt_d;
  // Index of the requester served most recently. It resets to 1 so that
  // requester 0 wins the first tie.
  logic                 last_q,  last_d;

  logic                 w_win_idx;

  // --------------------------------------------------------------------------
  // Winner selection, evaluated in IDLE only
  // --------------------------------------------------------------------------
  always_comb begin
    w_win_idx = 1'b0;
    if (req == 2'b10) begin
      w_win_idx = 1'b1;
    end else if (req == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_win_idx = 1'b0;
`else
      // On a tie, the requester that was not served last time wins.
      w_win_idx = ~last_q;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    func_d  = func_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (req != 2'b00) begin
          state_d = S_START;
          gnt_d   = w_win_idx ? 2'b10 : 2'b01;
          func_d  = w_win_idx ? func1 : func0;
          sel_d   = w_win_idx ? sel1  : sel0;
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // alu_end has priority, so completion on the expiry edge counts as
        // a success.
        if (alu_end) begin
          state_d = S_DONE;
          err_d   = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_q == c_cnt_last)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        err_d   = 1'b0;
        last_d  = gnt_q[1];
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        err_d   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      err_q   <= 1'b0;
      func_q  <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      func_q  <= func_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registers or decodes of the registered state only
  // --------------------------------------------------------------------------
  assign gnt        = gnt_q;
  assign done       = (state_q == S_DONE) ? gnt_q : 2'b00;
  assign err        = err_q;
  assign alu_start  = (state_q == S_START);
  assign alu_func   = func_q;
  assign alu_in_sel = sel_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed bench for alu_arbiter. Expected grant outcomes are
//               queued when a request is issued and compared when the DUT
//               pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned FUNC_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req = 2'b00;
  logic [FUNC_W-1:0] func0 = '0;
  logic [FUNC_W-1:0] func1 = '0;
  logic              sel0 = 1'b0;
  logic              sel1 = 1'b0;
  logic              alu_end = 1'b0;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              err;
  logic              alu_start;
  logic [FUNC_W-1:0] alu_func;
  logic              alu_in_sel;
  logic              busy;

  alu_arbiter #(
    .TIMEOUT (TIMEOUT),
    .FUNC_W  (FUNC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .func0      (func0),
    .func1      (func1),
    .sel0       (sel0),
    .sel1       (sel1),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .alu_start  (alu_start),
    .alu_func   (alu_func),
    .alu_in_sel (alu_in_sel),
    .alu_end    (alu_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        gnt;
    logic [FUNC_W-1:0] func;
    logic              sel;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic last_m = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected outcome of a request pattern using the current
  // func/sel inputs and the bench's own round-robin history.
  task automatic push_exp(input logic [1:0] r, input logic e);
    exp_t x;
    logic w;
    if (r == 2'b10) w = 1'b1;
    else if (r == 2'b01) w = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    else w = 1'b0;
`else
    else w = ~last_m;
`endif
    x.gnt  = w ? 2'b10 : 2'b01;
    x.func = w ? func1 : func0;
    x.sel  = w ? sel1 : sel0;
    x.err  = e;
    last_m = w;
    sb.push_back(x);
  endtask

  // Serve one queued operation. d = cycles from WAIT entry to the edge that
  // samples alu_end (negative: never). drop = requester 0 withdraws and
  // changes func0/sel0 one cycle after the grant.
  task automatic run_op(input int d, input bit drop, input logic [1:0] req_after);
    exp_t e;
    int   n;
    int   lat;
    int   exp_lat;
    if (sb.size() == 0) begin
      $display("FAIL sb_empty observed=0 expected=1");
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
    n = 0;
    while (!alu_start && n < 10) begin
      step();
      n++;
    end
    chk("start_lat",   n,          1);
    chk("gnt_start",   gnt,        e.gnt);
    chk("func_start",  alu_func,   e.func);
    chk("sel_start",   alu_in_sel, e.sel);
    chk("busy_start",  busy,       1);
    step();
    chk("start_1cyc",  alu_start,  0);
    lat = 0;
    while (done == 2'b00 && lat < 64) begin
      if (d >= 0 && lat == d - 1) alu_end = 1'b1;
      if (drop && lat == 0) begin
        req   = 2'b00;
        func0 = ~func0;
        sel0  = ~sel0;
      end
      step();
      alu_end = 1'b0;
      lat++;
    end
    exp_lat = (d < 0 || d > int'(TIMEOUT)) ? int'(TIMEOUT) : d;
    chk("done_lat",  lat,        exp_lat);
    chk("done",      done,       e.gnt);
    chk("err",       err,        e.err);
    chk("gnt_done",  gnt,        e.gnt);
    chk("func_done", alu_func,   e.func);
    chk("sel_done",  alu_in_sel, e.sel);
    req = req_after;
    step();
    chk("done_clr", done, 0);
    chk("err_clr",  err,  0);
    chk("gnt_clr",  gnt,  0);
    chk("busy_clr", busy, 0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = 2'b00;
    alu_end = 1'b0;
    step();
    step();
    rst     = 1'b0;
    last_m  = 1'b1;
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_busy",  busy,       0);
    chk("rst_gnt",   gnt,        0);
    chk("rst_done",  done,       0);
    chk("rst_err",   err,        0);
    chk("rst_start", alu_start,  0);
    chk("rst_func",  alu_func,   0);
    chk("rst_sel",   alu_in_sel, 0);
    step();
    rst = 1'b0;

    // Single requester 0, alu_end 3 cycles into WAIT
    func0 = 3'b010;
    sel0  = 1'b1;
    req   = 2'b01;
    push_exp(2'b01, 1'b0);
    run_op(3, 1'b0, 2'b00);
    step();
    chk("idle_hold_func", alu_func,   3'b010);
    chk("idle_hold_sel",  alu_in_sel, 1);

    // Both requesting for four operations
    do_reset();
    func0 = 3'b001;
    sel0  = 1'b0;
    func1 = 3'b110;
    sel1  = 1'b1;
    req   = 2'b11;
    for (int k = 0; k < 4; k++) push_exp(2'b11, 1'b0);
    for (int k = 0; k < 4; k++) run_op(2, 1'b0, (k == 3) ? 2'b00 : 2'b11);

    // Watchdog abort on requester 1
    func1 = 3'b101;
    sel1  = 1'b0;
    req   = 2'b10;
    push_exp(2'b10, 1'b1);
    run_op(-1, 1'b0, 2'b00);

    // alu_end on the expiry edge counts as success
    req = 2'b10;
    push_exp(2'b10, 1'b0);
    run_op(int'(TIMEOUT), 1'b0, 2'b00);

    // alu_end pulse while idle
    alu_end = 1'b1;
    step();
    alu_end = 1'b0;
    chk("idle_end_busy",  busy,      0);
    chk("idle_end_start", alu_start, 0);
    chk("idle_end_done",  done,      0);
    step();
    chk("idle_end_busy2", busy,      0);

    // Requester 0 drops req and changes func/sel after the grant
    func0 = 3'b011;
    sel0  = 1'b0;
    req   = 2'b01;
    push_exp(2'b01, 1'b0);
    run_op(2, 1'b1, 2'b00);

    // Reset in the middle of WAIT
    func0 = 3'b100;
    sel0  = 1'b1;
    req   = 2'b01;
    step();
    step();
    step();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",  busy,       0);
    chk("mid_rst_gnt",   gnt,        0);
    chk("mid_rst_done",  done,       0);
    chk("mid_rst_err",   err,        0);
    chk("mid_rst_start", alu_start,  0);
    chk("mid_rst_func",  alu_func,   0);
    chk("mid_rst_sel",   alu_in_sel, 0);
    req = 2'b00;
    step();
    rst    = 1'b0;
    last_m = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);

    // Normal service after the reset
    func0 = 3'b111;
    sel0  = 1'b1;
    req   = 2'b01;
    push_exp(2'b01, 1'b0);
    run_op(1, 1'b0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
